// File: rtl/ctrl_decode_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe_pkg
// Description : Shared encodings for the ID-stage control pipeline: mode
//               values, data-processing opcodes, ALU commands and the control
//               bundle carried by every pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_decode_pipe_pkg;

  // Instruction class carried in the mode field
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands seen by the EXE stage
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Control bundle, MSB first
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s_out;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Forces every control field to zero unless the owning stage is live
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic live);
    return live ? c : CTRL_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe_if
// Description : Instruction-in / controls-out bundle of the ID-stage control
//               pipeline. master = decode/hazard side, slave = the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_decode_pipe_if #(
  parameter int PAYLOAD_W = 32,
  parameter int CNT_W     = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [3:0]           op_code;
  logic                 s_in;
  logic                 cond_pass;
  logic                 uses_flags;
  logic [PAYLOAD_W-1:0] payload_in;
  logic                 stall;
  logic                 flush;
  logic                 out_valid;
  logic [3:0]           exe_cmd;
  logic                 mem_read;
  logic                 mem_write;
  logic                 wb_en;
  logic                 b;
  logic                 s_out;
  logic                 illegal;
  logic [PAYLOAD_W-1:0] payload_out;
  logic [CNT_W-1:0]     illegal_cnt;

  modport master (
    output in_valid, mode, op_code, s_in, cond_pass, uses_flags, payload_in, stall, flush,
    input  in_ready, out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, illegal,
           payload_out, illegal_cnt
  );

  modport slave (
    input  in_valid, mode, op_code, s_in, cond_pass, uses_flags, payload_in, stall, flush,
    output in_ready, out_valid, exe_cmd, mem_read, mem_write, wb_en, b, s_out, illegal,
           payload_out, illegal_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_decode_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe_decode
// Description : Purely combinational translation of mode/op_code/S into the
//               EXE/MEM/WB control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe_decode
  import ctrl_decode_pipe_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [3:0] op_code_i,
  input  logic       s_in_i,
  output ctrl_t      ctrl_o
);

  // Decode one instruction; every field starts at zero so unused enables stay low
  always_comb begin
    ctrl_o = CTRL_NONE;
    case (mode_i)
      MODE_DP: begin
        ctrl_o.s_out = s_in_i;
        ctrl_o.wb_en = 1'b1;
        case (op_code_i)
          OP_MOV: ctrl_o.exe_cmd = CMD_MOV;
          OP_MVN: ctrl_o.exe_cmd = CMD_MVN;
          OP_ADD: ctrl_o.exe_cmd = CMD_ADD;
          OP_ADC: ctrl_o.exe_cmd = CMD_ADC;
          OP_SUB: ctrl_o.exe_cmd = CMD_SUB;
          OP_SBC: ctrl_o.exe_cmd = CMD_SBC;
          OP_AND: ctrl_o.exe_cmd = CMD_AND;
          OP_ORR: ctrl_o.exe_cmd = CMD_ORR;
          OP_EOR: ctrl_o.exe_cmd = CMD_EOR;
          // Compare/test only update flags, so no register write-back
          OP_CMP: begin
            ctrl_o.exe_cmd = CMD_SUB;
            ctrl_o.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl_o.exe_cmd = CMD_AND;
            ctrl_o.wb_en   = 1'b0;
          end
          // Undefined opcode: harmless MOV with no side effects, flagged illegal
          default: begin
            ctrl_o.exe_cmd = CMD_MOV;
            ctrl_o.wb_en   = 1'b0;
            ctrl_o.s_out   = 1'b0;
            ctrl_o.illegal = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        // Address is always base + offset; S doubles as the L (load) bit
        ctrl_o.exe_cmd   = CMD_ADD;
        ctrl_o.mem_read  = s_in_i;
        ctrl_o.wb_en     = s_in_i;
        ctrl_o.mem_write = ~s_in_i;
      end
      MODE_BR: begin
        ctrl_o.exe_cmd = CMD_NOP;
        ctrl_o.b       = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe
// Description : ID-stage control unit followed by PIPE_DEPTH registered
//               stages carrying controls plus a sideband payload. Handles
//               stall/flush, condition-fail squash, NZCV flag hazards and a
//               saturating count of accepted illegal encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int PAYLOAD_W  = 32,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ctrl_decode_pipe_if.slave   bus
);

  localparam int LAST = PIPE_DEPTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t                w_dec;
  logic                 w_hazard_src;
  logic                 w_flag_hazard;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_load;
  ctrl_t                w_out_ctrl;

  logic                 valid_q [PIPE_DEPTH];
  logic                 valid_d [PIPE_DEPTH];
  ctrl_t                ctrl_q  [PIPE_DEPTH];
  ctrl_t                ctrl_d  [PIPE_DEPTH];
  logic [PAYLOAD_W-1:0] pay_q   [PIPE_DEPTH];
  logic [PAYLOAD_W-1:0] pay_d   [PIPE_DEPTH];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  ctrl_decode_pipe_decode u_decode (
    .mode_i    (bus.mode),
    .op_code_i (bus.op_code),
    .s_in_i    (bus.s_in),
    .ctrl_o    (w_dec)
  );

  // Any live in-flight instruction that will write NZCV blocks a flag reader
  always_comb begin
    w_hazard_src = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_hazard_src = w_hazard_src | (valid_q[i] & ctrl_q[i].s_out);
    end
  end

  assign w_flag_hazard = bus.uses_flags & w_hazard_src;
  assign w_in_ready    = ~bus.stall & ~w_flag_hazard;
  assign w_accept      = bus.in_valid & w_in_ready;
  // A failed condition is consumed but enters the pipe as a bubble
  assign w_load        = w_accept & bus.cond_pass;

  // Stage next-state: flush kills everything, stall freezes, otherwise shift.
  // Payload/controls only move with live entries so the last stage's payload
  // keeps its previous value while bubbles pass.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pay_d   = pay_q;
    if (bus.flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (!bus.stall) begin
      valid_d[0] = w_load;
      if (w_load) begin
        ctrl_d[0] = w_dec;
        pay_d[0]  = bus.payload_in;
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          ctrl_d[i] = ctrl_q[i-1];
          pay_d[i]  = pay_q[i-1];
        end
      end
    end
  end

  // Illegal-op count: counted at acceptance, even if flushed the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (w_load && w_dec.illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Stage and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= CTRL_NONE;
        pay_q[i]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        ctrl_q[i]  <= ctrl_d[i];
        pay_q[i]   <= pay_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  assign w_out_ctrl = gate_ctrl(ctrl_q[LAST], valid_q[LAST]);

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = valid_q[LAST];
  assign bus.exe_cmd     = w_out_ctrl.exe_cmd;
  assign bus.mem_read    = w_out_ctrl.mem_read;
  assign bus.mem_write   = w_out_ctrl.mem_write;
  assign bus.wb_en       = w_out_ctrl.wb_en;
  assign bus.b           = w_out_ctrl.b;
  assign bus.s_out       = w_out_ctrl.s_out;
  assign bus.illegal     = w_out_ctrl.illegal;
  assign bus.payload_out = pay_q[LAST];
  assign bus.illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_decode_pipe
// Description : Self-checking bench for ctrl_decode_pipe (PIPE_DEPTH=2).
//               A slot-list model tracks expected outputs every cycle;
//               directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_decode_pipe;

  localparam int PD = 2;
  localparam int PW = 32;
  localparam int CW = 8;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_decode_pipe_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

  ctrl_decode_pipe #(.PIPE_DEPTH(PD), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference rules ----------------
  // Result packed as {cmd[3:0], mem_read, mem_write, wb_en, b, s_out, illegal}
  function automatic logic [9:0] ref_decode(input logic [1:0] m, input logic [3:0] op, input logic s);
    logic [3:0] cmd;
    logic       wb;
    logic       ok;
    cmd = 4'b0001; wb = 1'b1; ok = 1'b1;
    if (m == 2'b01) return {4'b0010, s, ~s, s, 1'b0, 1'b0, 1'b0};
    if (m == 2'b10) return {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    if (m == 2'b11) return {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    case (op)
      4'b1101: cmd = 4'b0001;
      4'b1111: cmd = 4'b1001;
      4'b0100: cmd = 4'b0010;
      4'b0101: cmd = 4'b0011;
      4'b0010: cmd = 4'b0100;
      4'b0110: cmd = 4'b0101;
      4'b0000: cmd = 4'b0110;
      4'b1100: cmd = 4'b0111;
      4'b0001: cmd = 4'b1000;
      4'b1010: begin cmd = 4'b0100; wb = 1'b0; end
      4'b1000: begin cmd = 4'b0110; wb = 1'b0; end
      default: ok = 1'b0;
    endcase
    if (!ok) return {4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    return {cmd, 1'b0, 1'b0, wb, 1'b0, s, 1'b0};
  endfunction

  // Model: slot k holds the instruction k+1 edges after its acceptance
  logic          m_v [PD];
  logic [9:0]    m_c [PD];
  logic [PW-1:0] m_p [PD];
  int            m_cnt = 0;

  initial begin
    for (int i = 0; i < PD; i++) begin
      m_v[i] = 1'b0; m_c[i] = '0; m_p[i] = '0;
    end
  end

  function automatic logic m_ready();
    logic busy;
    busy = 1'b0;
    for (int i = 0; i < PD; i++) busy = busy | (m_v[i] & m_c[i][1]);
    return !bus.stall && !(bus.uses_flags && busy);
  endfunction

  always @(posedge clk) begin : model
    logic       acc;
    logic [9:0] d;
    acc = bus.in_valid && m_ready();
    d   = ref_decode(bus.mode, bus.op_code, bus.s_in);
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) m_v[i] = 1'b0;
      m_cnt = 0;
    end else begin
      if (acc && bus.cond_pass && d[0] && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
      if (bus.flush) begin
        for (int i = 0; i < PD; i++) m_v[i] = 1'b0;
      end else if (!bus.stall) begin
        for (int i = PD - 1; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_c[i] = m_c[i-1]; m_p[i] = m_p[i-1];
        end
        m_v[0] = acc && bus.cond_pass;
        m_c[0] = d;
        m_p[0] = bus.payload_in;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_ctrl();
    return {bus.exe_cmd, bus.mem_read, bus.mem_write, bus.wb_en, bus.b, bus.s_out, bus.illegal};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_v[PD-1]));
      chk("ctrl", 64'(dut_ctrl()), m_v[PD-1] ? 64'(m_c[PD-1]) : 64'd0);
      chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(m_cnt));
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      if (m_v[PD-1]) chk("payload_out", 64'(bus.payload_out), 64'(m_p[PD-1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic cp, input logic uf, input logic [PW-1:0] p);
    bus.in_valid = v; bus.mode = m; bus.op_code = op; bus.s_in = s;
    bus.cond_pass = cp; bus.uses_flags = uf; bus.payload_in = p;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst ctrl", 64'(dut_ctrl()), 64'd0);
    chk("rst payload", 64'(bus.payload_out), 64'd0);
    chk("rst cnt", 64'(bus.illegal_cnt), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // 1: ADD with S, visible two edges after acceptance
    drive(1, 2'b00, 4'b0100, 1, 1, 0, 32'hA0A0);
    step();
    idle();
    @(negedge clk);
    chk("add early out_valid", 64'(bus.out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("add out_valid", 64'(bus.out_valid), 64'd1);
    chk("add exe_cmd", 64'(bus.exe_cmd), 64'h2);
    chk("add wb_en", 64'(bus.wb_en), 64'd1);
    chk("add s_out", 64'(bus.s_out), 64'd1);
    chk("add payload", 64'(bus.payload_out), 64'hA0A0);
    step(); step();

    // 2: CMP sets flags, then ADC reading flags waits until CMP leaves
    drive(1, 2'b00, 4'b1010, 1, 1, 0, 32'h1);
    step();
    drive(1, 2'b00, 4'b0101, 1, 1, 1, 32'h2);
    @(negedge clk);
    chk("haz ready0", 64'(bus.in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("haz ready1", 64'(bus.in_ready), 64'd0);
    chk("cmp exe_cmd", 64'(bus.exe_cmd), 64'h4);
    chk("cmp wb_en", 64'(bus.wb_en), 64'd0);
    step();
    @(negedge clk);
    chk("haz ready2", 64'(bus.in_ready), 64'd1);
    step();
    idle();
    step();
    @(negedge clk);
    chk("adc exe_cmd", 64'(bus.exe_cmd), 64'h3);
    chk("adc payload", 64'(bus.payload_out), 64'h2);
    step(); step();

    // 3: load then store
    drive(1, 2'b01, 4'b0000, 1, 1, 0, 32'h3);
    step();
    drive(1, 2'b01, 4'b0110, 0, 1, 0, 32'h4);
    step();
    @(negedge clk);
    chk("ldr mem_read", 64'(bus.mem_read), 64'd1);
    chk("ldr wb_en", 64'(bus.wb_en), 64'd1);
    chk("ldr exe_cmd", 64'(bus.exe_cmd), 64'h2);
    chk("ldr mem_write", 64'(bus.mem_write), 64'd0);
    idle();
    step();
    @(negedge clk);
    chk("str mem_write", 64'(bus.mem_write), 64'd1);
    chk("str wb_en", 64'(bus.wb_en), 64'd0);
    chk("str mem_read", 64'(bus.mem_read), 64'd0);

    // squashed illegal (not counted) then live illegal (counted)
    drive(1, 2'b00, 4'b0011, 1, 0, 0, 32'h5);
    step();
    drive(1, 2'b00, 4'b0011, 1, 1, 0, 32'h6);
    step();
    idle();
    step();
    @(negedge clk);
    chk("ill cnt", 64'(bus.illegal_cnt), 64'd1);
    chk("ill out_valid", 64'(bus.out_valid), 64'd1);
    chk("ill flag", 64'(bus.illegal), 64'd1);
    chk("ill exe_cmd", 64'(bus.exe_cmd), 64'h1);
    chk("ill wb_en", 64'(bus.wb_en), 64'd0);

    // 4: branch accepted under flush never appears
    drive(1, 2'b10, 4'b0000, 0, 1, 0, 32'h7);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("br out_valid", 64'(bus.out_valid), 64'd0);
      chk("br b", 64'(bus.b), 64'd0);
      step();
    end

    // 5: reserved mode hammered until the counter saturates
    for (int k = 0; k < 260; k++) begin
      drive(1, 2'b11, 4'(k), 0, 1, 0, PW'(k + 100));
      step();
    end
    @(negedge clk);
    chk("sat cnt", 64'(bus.illegal_cnt), 64'd255);
    chk("sat out_valid", 64'(bus.out_valid), 64'd1);
    chk("sat illegal", 64'(bus.illegal), 64'd1);
    idle();
    step(); step();

    // 6: stall mid-stream freezes, then reset clears everything
    drive(1, 2'b00, 4'b0100, 0, 1, 0, 32'd10);
    step();
    drive(1, 2'b00, 4'b0010, 0, 1, 0, 32'd11);
    step();
    drive(1, 2'b00, 4'b0001, 0, 1, 0, 32'd12);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("stall exe_cmd", 64'(bus.exe_cmd), 64'h2);
      chk("stall payload", 64'(bus.payload_out), 64'd10);
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.stall = 1'b0;
    step();
    idle();
    @(negedge clk);
    chk("post sub exe_cmd", 64'(bus.exe_cmd), 64'h4);
    chk("post sub payload", 64'(bus.payload_out), 64'd11);
    step();
    @(negedge clk);
    chk("post eor exe_cmd", 64'(bus.exe_cmd), 64'h8);
    chk("post eor payload", 64'(bus.payload_out), 64'd12);
    drive(1, 2'b00, 4'b1101, 0, 1, 0, 32'd13);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid rst ctrl", 64'(dut_ctrl()), 64'd0);
    chk("mid rst payload", 64'(bus.payload_out), 64'd0);
    chk("mid rst cnt", 64'(bus.illegal_cnt), 64'd0);
    idle();
    rst_n = 1'b1;
    step(); step(); step();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
